// File: rtl/led_pwm_ctrl.sv
// Three-channel LED PWM controller with a frame-aligned config handshake and
// shared blink/breathe effects; all channel updates land on PWM frame boundaries.
module led_pwm_ctrl #(
  parameter int PRESCALE     = 188,
  parameter int BLINK_FRAMES = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_chan,
  input  logic [1:0] cfg_mode,
  input  logic [7:0] cfg_duty,
  output logic [2:0] pwm_rgb,
  output logic       frame_start
);

  typedef enum logic [1:0] {MODE_OFF, MODE_STATIC, MODE_BLINK, MODE_BREATHE} mode_e;
  typedef enum logic {ST_IDLE, ST_PENDING} state_e;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] r_presc;
  logic [7:0]    r_cnt;
  logic          r_frame;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic [7:0]    r_level;
  logic          r_down;
  mode_e         r_mode [3];
  logic [7:0]    r_duty [3];
  logic [2:0]    r_pwm;
  state_e        r_state;
  logic          r_ready;
  logic [1:0]    r_sh_chan;
  mode_e         r_sh_mode;
  logic [7:0]    r_sh_duty;

  logic          w_step;
  logic [BW-1:0] w_blink_cnt_nxt;
  logic          w_phase_nxt;
  logic [7:0]    w_level_nxt;
  logic          w_down_nxt;
  mode_e         w_mode_nxt [3];
  logic [7:0]    w_duty_nxt [3];
  logic [15:0]   w_prod [3];
  logic [7:0]    w_eff [3];

  assign w_step = (r_presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_presc <= w_step ? '0 : r_presc + PW'(1);
      if (w_step) r_cnt <= r_cnt + 8'd1;
      r_frame <= w_step && (r_cnt == 8'hFF);
    end
  end

  // Shared effect counters advance once per frame; the level bounces off 0 and 255 without dwelling.
  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt;
    w_phase_nxt     = r_phase;
    w_level_nxt     = r_level;
    w_down_nxt      = r_down;
    if (r_frame) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_nxt = '0;
        w_phase_nxt     = ~r_phase;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BW'(1);
      end
      if (r_down) begin
        if (r_level == 8'd0) begin
          w_down_nxt  = 1'b0;
          w_level_nxt = 8'd1;
        end else begin
          w_level_nxt = r_level - 8'd1;
        end
      end else begin
        if (r_level == 8'hFF) begin
          w_down_nxt  = 1'b1;
          w_level_nxt = 8'hFE;
        end else begin
          w_level_nxt = r_level + 8'd1;
        end
      end
    end
  end

  // Effective duty uses the settings that govern the upcoming output cycle, so a frame never mixes old and new.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_mode_nxt[i] = r_mode[i];
      w_duty_nxt[i] = r_duty[i];
      if (r_frame && (r_state == ST_PENDING) &&
          ((r_sh_chan == 2'(i)) || (r_sh_chan == 2'd3))) begin
        w_mode_nxt[i] = r_sh_mode;
        w_duty_nxt[i] = r_sh_duty;
      end
      w_prod[i] = {8'd0, w_duty_nxt[i]} * {8'd0, w_level_nxt};
      w_eff[i]  = 8'd0;
      case (w_mode_nxt[i])
        MODE_OFF:     w_eff[i] = 8'd0;
        MODE_STATIC:  w_eff[i] = w_duty_nxt[i];
        MODE_BLINK:   w_eff[i] = w_phase_nxt ? w_duty_nxt[i] : 8'd0;
        MODE_BREATHE: w_eff[i] = w_prod[i][15:8];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_level     <= 8'd0;
      r_down      <= 1'b0;
      r_pwm       <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_mode[i] <= MODE_OFF;
        r_duty[i] <= 8'd0;
      end
    end else begin
      r_blink_cnt <= w_blink_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_level     <= w_level_nxt;
      r_down      <= w_down_nxt;
      for (int i = 0; i < 3; i++) begin
        r_mode[i] <= w_mode_nxt[i];
        r_duty[i] <= w_duty_nxt[i];
        r_pwm[i]  <= (r_cnt < w_eff[i]);
      end
    end
  end

  // Single shadow entry: hold off new requests until the frame boundary has consumed it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b1;
      r_sh_chan <= 2'd0;
      r_sh_mode <= MODE_OFF;
      r_sh_duty <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_valid) begin
            r_sh_chan <= cfg_chan;
            r_sh_mode <= mode_e'(cfg_mode);
            r_sh_duty <= cfg_duty;
            r_state   <= ST_PENDING;
            r_ready   <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (r_frame) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign cfg_ready   = r_ready;
  assign pwm_rgb     = r_pwm;
  assign frame_start = r_frame;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Scoreboard bench for led_pwm_ctrl: a frame-level model predicts high cycles per
// channel per frame; a monitor measures each output frame and compares.
module tb_led_pwm_ctrl;

  localparam int PRESCALE     = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_CYC    = 256 * PRESCALE;

  typedef struct {
    int frame;
    int hi0;
    int hi1;
    int hi2;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cfgValid = 1'b0;
  logic [1:0] cfgChan = 2'd0;
  logic [1:0] cfgMode = 2'd0;
  logic [7:0] cfgDuty = 8'd0;
  logic       cfgReady;
  logic [2:0] pwmRgb;
  logic       frameStart;

  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];

  int mMode[3];
  int mDuty[3];
  bit mHave = 1'b0;
  int pChan, pMode, pDuty;
  int mCyc = 0;
  int mFrame = 0;
  bit mFsNow = 1'b0;

  led_pwm_ctrl #(.PRESCALE(PRESCALE), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clock),
    .reset(reset),
    .cfg_valid(cfgValid),
    .cfg_ready(cfgReady),
    .cfg_chan(cfgChan),
    .cfg_mode(cfgMode),
    .cfg_duty(cfgDuty),
    .pwm_rgb(pwmRgb),
    .frame_start(frameStart)
  );

  always #5 clock = ~clock;

  function automatic int levelAt(int k);
    int m;
    m = k % 510;
    return (m <= 255) ? m : 510 - m;
  endfunction

  // High cycles in frame k, straight from the mode definitions.
  function automatic int highCount(int mode, int duty, int k);
    case (mode)
      0:       return 0;
      1:       return duty;
      2:       return (((k / BLINK_FRAMES) % 2) == 1) ? duty : 0;
      default: return (duty * levelAt(k)) / 256;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    bit acc, clr, rst;
    exp_t e;
    rst = reset;
    acc = cfgValid && !mHave && !rst;
    clr = mFsNow && mHave;
    @(posedge clock);
    #1;
    if (rst) begin
      mFsNow = 1'b0;
      return;
    end
    mCyc++;
    if (clr) mHave = 1'b0;
    if (acc) begin
      mHave = 1'b1;
      pChan = cfgChan;
      pMode = cfgMode;
      pDuty = cfgDuty;
    end
    mFsNow = ((mCyc % FRAME_CYC) == 0);
    if (frameStart || mFsNow) checkOutput("frame_start", frameStart, mFsNow);
    if (mFsNow) begin
      mFrame++;
      if (mHave) begin
        for (int i = 0; i < 3; i++) begin
          if (pChan == i || pChan == 3) begin
            mMode[i] = pMode;
            mDuty[i] = pDuty;
          end
        end
      end
      e.frame = mFrame;
      e.hi0 = highCount(mMode[0], mDuty[0], mFrame);
      e.hi1 = highCount(mMode[1], mDuty[1], mFrame);
      e.hi2 = highCount(mMode[2], mDuty[2], mFrame);
      expQ.push_back(e);
    end
    if (cfgValid || mFsNow) checkOutput("cfg_ready", cfgReady, mHave ? 0 : 1);
  endtask

  task automatic idle(input int n);
    repeat (n) stepCycle();
  endtask

  task automatic waitFrame();
    for (int n = 0; n < FRAME_CYC + 4; n++) begin
      stepCycle();
      if (mFsNow) break;
    end
  endtask

  task automatic applyStimulus(input int chan, input int mode, input int duty);
    bit done;
    bit willAcc;
    done = 1'b0;
    cfgChan  = 2'(chan);
    cfgMode  = 2'(mode);
    cfgDuty  = 8'(duty);
    cfgValid = 1'b1;
    for (int n = 0; n < 2 * FRAME_CYC + 8; n++) begin
      willAcc = !mHave;
      stepCycle();
      if (willAcc) begin
        done = 1'b1;
        break;
      end
    end
    cfgValid = 1'b0;
    if (!done) checkOutput("handshake_timeout", 0, 1);
  endtask

  task automatic applyReset(input int n);
    reset    = 1'b1;
    cfgValid = 1'b0;
    repeat (n) begin
      stepCycle();
      checkOutput("reset_pwm", pwmRgb, 0);
      checkOutput("reset_ready", cfgReady, 1);
      checkOutput("reset_frame_start", frameStart, 0);
    end
    mHave  = 1'b0;
    mCyc   = 0;
    mFrame = 0;
    mFsNow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mMode[i] = 0;
      mDuty[i] = 0;
    end
    expQ.delete();
    reset = 1'b0;
    stepCycle();
    checkOutput("post_reset_pwm", pwmRgb, 0);
    checkOutput("post_reset_ready", cfgReady, 1);
  endtask

  // Monitor: accumulate high cycles per output frame and close the window on each frame_start.
  initial begin
    int  acc[3];
    bit  skipWin;
    bit  rstEdge;
    exp_t e;
    skipWin = 1'b1;
    for (int i = 0; i < 3; i++) acc[i] = 0;
    forever begin
      @(posedge clock);
      rstEdge = reset;
      #1;
      if (rstEdge) begin
        for (int i = 0; i < 3; i++) acc[i] = 0;
        skipWin = 1'b1;
        continue;
      end
      for (int i = 0; i < 3; i++) acc[i] += int'(pwmRgb[i]);
      if (frameStart) begin
        if (skipWin) begin
          skipWin = 1'b0;
        end else if (expQ.size() == 0) begin
          checkOutput("scoreboard_depth", 0, 1);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("frame%0d_red", e.frame), acc[0], e.hi0);
          checkOutput($sformatf("frame%0d_green", e.frame), acc[1], e.hi1);
          checkOutput($sformatf("frame%0d_blue", e.frame), acc[2], e.hi2);
        end
        for (int i = 0; i < 3; i++) acc[i] = 0;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyReset(4);

    idle(40);  applyStimulus(2, 3, 255); waitFrame();
    idle(30);  applyStimulus(0, 1, 64);  waitFrame();
    idle(50);  applyStimulus(1, 1, 255);
    checkOutput("ready_after_accept", cfgReady, 0);
    applyStimulus(0, 1, 0);
    waitFrame();
    idle(20);  applyStimulus(3, 1, 255); waitFrame();
    idle(20);  applyStimulus(2, 3, 255); waitFrame();
    idle(20);  applyStimulus(0, 2, 128); waitFrame();
    idle(20);  applyStimulus(1, 0, 0);   waitFrame();
    repeat (4) waitFrame();

    while (mFrame < 260) begin
      if ($urandom_range(0, 3) != 0) begin
        idle(int'($urandom_range(1, 200)));
        applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 255)));
      end
      waitFrame();
    end

    idle(10);
    applyStimulus(1, 1, 200);
    idle(5);
    applyReset(3);
    repeat (3) waitFrame();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pwm_ctrl.md
LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 188, meaning clk cycles per PWM count step (48 MHz / 188 / 256 ≈ 1 kHz PWM frame); legal range 1..65535.
REQ-002 SHALL have parameter BLINK_FRAMES, default 250, meaning PWM frames per blink half-period; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  sole clock (clk_48m domain).
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_valid  input  1  config request valid.
REQ-006 SHALL have port cfg_ready  output  1  controller can accept a config request.
REQ-007 SHALL have port cfg_chan  input  2  target channel: 0=red, 1=green, 2=blue, 3=all three.
REQ-008 SHALL have port cfg_mode  input  2  mode: 0=OFF, 1=STATIC, 2=BLINK, 3=BREATHE.
REQ-009 SHALL have port cfg_duty  input  8  channel duty, 0..255.
REQ-010 SHALL have port pwm_rgb  output  3  PWM drive to the RGB LED driver PWM inputs, bit0=red, bit1=green, bit2=blue; active-high.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse on the first cycle of each PWM frame.

Function
REQ-012 SHALL have a prescaler that counts 0..PRESCALE-1, wraps to 0, and issues step=1 on the wrap cycle.
REQ-013 SHALL advance an 8-bit pwm_cnt by 1 on each step, wrapping 255->0; frame_start SHALL pulse in the cycle pwm_cnt becomes 0.
REQ-014 SHALL register pwm_rgb[i] = (pwm_cnt < duty_eff[i]), so duty_eff 0 gives constant 0 and 255 gives 255/256 high, with no glitches within a count step.
REQ-015 SHALL accept a config request on a cycle with cfg_valid=1 and cfg_ready=1, latch chan/mode/duty into shadow registers, and drive cfg_ready=0 on the next cycle.
REQ-016 Config FSM SHALL have two states: IDLE (cfg_ready=1) goes to PENDING on a handshake; PENDING (cfg_ready=0) goes to IDLE on the cycle frame_start pulses.
REQ-017 On the frame_start cycle in PENDING, SHALL copy shadow mode/duty into the active registers of the addressed channel(s); cfg_chan=3 updates all three channels.
REQ-018 Active settings SHALL change only at frame boundaries; a request accepted in the frame_start cycle itself SHALL commit at the next frame_start.
REQ-019 A blink frame counter SHALL count frame_start pulses 0..BLINK_FRAMES-1, toggle blink_phase on wrap, and be shared by all channels.
REQ-020 A breathe level, 8-bit, SHALL move ±1 per frame as a triangle wave: at 255 it SHALL turn to down, at 0 it SHALL turn to up, with no hold at either endpoint; it SHALL be shared by all channels.
REQ-021 duty_eff SHALL be: OFF=0; STATIC=duty; BLINK=duty when blink_phase=1, else 0; BREATHE=(duty*level)>>8, with a 16-bit product and the upper 8 bits taken.
REQ-022 Changing a channel's mode SHALL NOT reset the shared blink or breathe counters.
REQ-023 cfg_chan, cfg_mode and cfg_duty SHALL be ignored when cfg_valid=0 or cfg_ready=0; no request is queued beyond the single shadow entry.

Reset
REQ-024 While reset=1 at a clk edge, SHALL clear prescaler, pwm_cnt, blink counter and blink_phase; set level=0 with direction up; set all channels to OFF with duty 0; clear the shadow registers.
REQ-025 During and after reset, pwm_rgb SHALL be 3'b000, frame_start=0 and cfg_ready=1, with the FSM in IDLE.
REQ-026 Reset asserted while PENDING SHALL discard the pending request; no channel update SHALL occur.

Verification (PRESCALE=1, BLINK_FRAMES=2 unless stated)
REQ-027 Static: request chan=0, mode=STATIC, duty=64 -> from the next frame, red is high for exactly 64 of 256 cycles and green/blue stay 0.
REQ-028 Handshake/boundary: issue a request mid-frame, then hold cfg_valid=1 with a second request -> cfg_ready=0 until frame_start, first request commits there, second is accepted on the following cycle and commits one frame later.
REQ-029 Extremes: duty=0 -> 0 high cycles per frame; duty=255 -> 255 high cycles per frame; chan=3 -> all three bits identical.
REQ-030 Blink: mode=BLINK, duty=128 -> alternating runs of 2 frames with 128 high cycles and 2 frames with 0 high cycles.
REQ-031 Breathe: mode=BREATHE, duty=255 -> frame k after reset has ((255*k)>>8) high cycles for k ≤ 255, then decreases by the same rule; level turns at 255 and at 0.
REQ-032 Reset mid-PENDING: request green STATIC, duty=200, then pulse reset before frame_start -> pwm_rgb stays 000 and cfg_ready=1 after reset.
